pbg_tx: RTL

Serial parity-framed transmitter: the sending end of the 4-bit-plus-parity link whose receive side is the `pbc` parity-error checker. It accepts one data word through a valid/ready handshake and computes its parity bit. It then shifts out a frame on a single line: start bit, data MSB first, parity bit, stop bit. The line pattern is chosen so that a downstream deserializer feeding `pbc` sees `pec = 0` for every clean frame.

---
 rtl/pbg_tx.sv | 80 ++++++++
 1 files changed

// File: rtl/pbg_tx.sv
// pbg_tx: serial parity-framed transmitter sending start, data MSB first, parity, stop
module pbg_tx #(
  parameter int DATA_W = 4,
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              p,
  output logic              busy,
  output logic              done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT + 1) : 1;
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W + 1) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] sh_nxt;
  logic last;
  logic par;
  assign last = cnt == CW'(CLKS_PER_BIT - 1);
  assign par = PARITY_ODD ? ~^data : ^data;
  assign sh_nxt = sh << 1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      ready <= 1'b1;
      tx <= 1'b1;
      p <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt <= (state == IDLE || last) ? '0 : cnt + CW'(1);
      done <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          sh <= data;
          p <= par;
          state <= START;
          tx <= 1'b0;
          ready <= 1'b0;
          busy <= 1'b1;
        end
        START: if (last) begin
          state <= DATA;
          idx <= '0;
          tx <= sh[DATA_W-1];
        end
        DATA: if (last) begin
          sh <= sh_nxt;
          idx <= idx + IW'(1);
          state <= idx == IW'(DATA_W - 1) ? PARITY : DATA;
          tx <= idx == IW'(DATA_W - 1) ? p : sh_nxt[DATA_W-1];
        end
        PARITY: if (last) begin
          state <= STOP;
          tx <= 1'b1;
          done <= CLKS_PER_BIT == 1;
        end
        STOP: if (last) begin
          state <= IDLE;
          ready <= 1'b1;
          busy <= 1'b0;
        end else begin
          done <= cnt == CW'(CLKS_PER_BIT - 2);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
